// File: rtl/mc14433_readout.sv
`default_nettype none
// =============================================================================
// mc14433_readout : synchronizes the MC14433 scan bus and captures one in-order
// DS1..DS4 frame per EOC into a valid/ready register. Option: READOUT_BIN_EN.
// Rev 1.0
// =============================================================================
module mc14433_readout #(
   parameter int SAMPLE_DLY = 2,
   parameter int TIMEOUT    = 255
) (
   input  logic        CP,
   input  logic        RB,
   input  logic [3:0]  Q,
   input  logic [3:0]  DS,
   input  logic        EOC,
   input  logic        RDY,
   output logic        VLD,
   output logic        HALF,
   output logic        POL,
   output logic        OVR,
   output logic [3:0]  D2,
   output logic [3:0]  D3,
   output logic [3:0]  D4,
   output logic        BERR,
   output logic        SEQERR,
   output logic        DROP,
   output logic [11:0] BIN
);
   localparam logic [3:0]  DLY_TC = SAMPLE_DLY[3:0];
   localparam logic [15:0] TO_TC  = TIMEOUT[15:0];

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DLY, S_NEXT} state_t;
   state_t state;

   logic [3:0]  q_m, q_s;
   logic [4:0]  pin_m, pin_s, pin_d;
   logic [3:0]  ds_s, ds_rise, exp_bit;
   logic        eoc_rise, ds_cur, sample, abort, load, re_arm, berr_new;
   logic [1:0]  idx;
   logic [3:0]  dcnt;
   logic [15:0] tcnt;
   logic        armed;
   logic        half_sh, pol_sh, ovr_sh;
   logic [3:0]  d2_sh, d3_sh;

   // Only strobes and EOC need the third copy for edge detection; Q is just sampled.
   always_ff @(posedge CP or negedge RB) begin
      if (!RB) begin
         q_m   <= '0;
         q_s   <= '0;
         pin_m <= '0;
         pin_s <= '0;
         pin_d <= '0;
      end else begin
         q_m   <= Q;
         q_s   <= q_m;
         pin_m <= {EOC, DS};
         pin_s <= pin_m;
         pin_d <= pin_s;
      end
   end

   assign ds_s     = pin_s[3:0];
   assign ds_rise  = pin_s[3:0] & ~pin_d[3:0];
   assign eoc_rise = pin_s[4] & ~pin_d[4];
   assign ds_cur   = ds_s[idx];
   assign exp_bit  = 4'b0001 << (idx + 2'd1);
   assign sample   = (state == S_DLY) && ds_cur && (dcnt == DLY_TC);
   assign load     = sample && (idx == 2'd3) && (!VLD || RDY);
   assign re_arm   = armed || eoc_rise;
   assign berr_new = (d2_sh > 4'd9) || (d3_sh > 4'd9) || (q_s > 4'd9);

   // A wrong strobe wins over the expected one; timeout only matters with no rise.
   always_comb begin
      abort = 1'b0;
      case (state)
         S_DLY:   abort = !ds_cur;
         S_NEXT:  abort = ((ds_rise & ~exp_bit) != 4'd0) ||
                          (((ds_rise & exp_bit) == 4'd0) && (tcnt == TO_TC));
         default: abort = 1'b0;
      endcase
   end

   always_ff @(posedge CP or negedge RB) begin
      if (!RB) begin
         state   <= S_IDLE;
         armed   <= 1'b0;
         idx     <= '0;
         dcnt    <= '0;
         tcnt    <= '0;
         half_sh <= 1'b0;
         pol_sh  <= 1'b0;
         ovr_sh  <= 1'b0;
         d2_sh   <= '0;
         d3_sh   <= '0;
         VLD     <= 1'b0;
         HALF    <= 1'b0;
         POL     <= 1'b0;
         OVR     <= 1'b0;
         D2      <= '0;
         D3      <= '0;
         D4      <= '0;
         BERR    <= 1'b0;
         SEQERR  <= 1'b0;
         DROP    <= 1'b0;
      end else begin
         SEQERR <= abort;
         if (eoc_rise)
            armed <= 1'b1;
         if (VLD && RDY)
            VLD <= 1'b0;
         case (state)
            S_IDLE: begin
               if (armed)
                  state <= S_ARMED;
            end
            S_ARMED: begin
               if (ds_rise[0]) begin
                  state <= S_DLY;
                  idx   <= 2'd0;
                  dcnt  <= 4'd1;
                  if (!eoc_rise)
                     armed <= 1'b0;
               end
            end
            S_DLY: begin
               if (abort) begin
                  state <= re_arm ? S_ARMED : S_IDLE;
               end else if (sample) begin
                  case (idx)
                     2'd0: begin
                        half_sh <= ~q_s[3];
                        pol_sh  <= q_s[2];
                        ovr_sh  <= q_s[0];
                     end
                     2'd1: d2_sh <= q_s;
                     2'd2: d3_sh <= q_s;
                     default: begin
                        if (load) begin
                           VLD  <= 1'b1;
                           HALF <= half_sh;
                           POL  <= pol_sh;
                           OVR  <= ovr_sh;
                           D2   <= d2_sh;
                           D3   <= d3_sh;
                           D4   <= q_s;
                           BERR <= berr_new;
                        end else begin
                           DROP <= 1'b1;
                        end
                     end
                  endcase
                  if (idx == 2'd3) begin
                     state <= re_arm ? S_ARMED : S_IDLE;
                  end else begin
                     state <= S_NEXT;
                     tcnt  <= 16'd1;
                  end
               end else begin
                  dcnt <= dcnt + 4'd1;
               end
            end
            default: begin
               if (abort) begin
                  state <= re_arm ? S_ARMED : S_IDLE;
               end else if ((ds_rise & exp_bit) != 4'd0) begin
                  state <= S_DLY;
                  idx   <= idx + 2'd1;
                  dcnt  <= 4'd1;
               end else begin
                  tcnt <= tcnt + 16'd1;
               end
            end
         endcase
      end
   end

`ifdef READOUT_BIN_EN
   logic [11:0] mag, bin_new;

   always_comb begin
      mag = (half_sh ? 12'd1000 : 12'd0) + ({8'd0, d2_sh} * 12'd100) +
            ({8'd0, d3_sh} * 12'd10) + {8'd0, q_s};
      if (berr_new || ovr_sh)
         bin_new = 12'd0;
      else if (pol_sh)
         bin_new = mag;
      else
         bin_new = -mag;
   end

   always_ff @(posedge CP or negedge RB) begin
      if (!RB)
         BIN <= '0;
      else if (load)
         BIN <= bin_new;
   end
`else
   assign BIN = 12'h000;
`endif

endmodule
`default_nettype wire
